uart_rx_fifo: RTL and testbench
===============================

// Module: uart_rx_fifo
// PURPOSE
//  Downstream consumer of the UART receiver. Accepts each byte it offers (RxReady/RxEnable), buffers bytes in a
//  FIFO with a valid/read interface, and recovers the receiver from its ERROR state by pulsing its reset.
//  The receiver only leaves ERROR via reset, so this block owns that recovery and keeps error statistics.
// PARAMETERS
//  ADDR_WIDTH       4   FIFO depth = 2**ADDR_WIDTH bytes
//  RECOVER_CYCLES   4   cycles UartResetN is held low after an error (>=1)
// PORTS
//  Clk             in   1             system clock, all logic on posedge
//  RxSamplerReset  in   1             reset, asynchronous, active-low
//  RxDataIn        in   8             byte from receiver, valid while RxReady=1
//  RxReady         in   1             receiver holds a complete byte
//  RxError         in   1             receiver in ERROR state (framing error / overrun)
//  RxEnable        out  1             one-cycle acknowledge to receiver; byte consumed
//  UartResetN      out  1             active-low reset to the receiver
//  DataOut         out  8             FIFO head byte
//  DataValid       out  1             FIFO not empty
//  DataRead        in   1             pop head when DataValid=1
//  Count           out  ADDR_WIDTH+1  bytes held, 0..2**ADDR_WIDTH
//  Full            out  1             Count == 2**ADDR_WIDTH
//  ErrorCount      out  8             receiver errors seen, saturates at 255
//  Overrun         out  1             sticky: error seen while Full
//  ClearStatus     in   1             sync clear of ErrorCount and Overrun
// BEHAVIOUR
//  Reset values: RxEnable=0, UartResetN=0, DataValid=0, Count=0, Full=0, ErrorCount=0, Overrun=0, state IDLE,
//   pointers 0. All outputs registered. UartResetN goes 1 on the first edge after reset release.
//  FSM (registered), states IDLE, ACK, RECOVER, SETTLE:
//   IDLE: RxError=1 -> RECOVER. UartResetN<=0, load counter RECOVER_CYCLES-1, ErrorCount+=1 (sat),
//         Overrun<=1 if Full. RxError has priority over RxReady.
//         Else RxReady=1 & !Full -> push RxDataIn, RxEnable<=1, -> ACK.
//         RxReady=1 & Full -> no push, no ack. Receiver is back-pressured and holds its byte.
//   ACK: RxEnable<=0 -> IDLE. The receiver left FULL on the ack edge, so RxReady is low in the next IDLE cycle.
//        Exactly one push per byte.
//   RECOVER: counter decrements each cycle. At 0: UartResetN<=1 -> SETTLE. Low time = RECOVER_CYCLES cycles.
//   SETTLE: one idle cycle; RxReady/RxError ignored -> IDLE.
//  FIFO:
//   Push at the IDLE edge above. DataOut/DataValid update on that same edge, so latency is 1 cycle from
//    RxReady seen to DataValid.
//   Pop when DataRead & DataValid. DataRead while empty is ignored (no pointer/count change).
//   Simultaneous push and pop: both happen, Count unchanged.
//   Push is gated by Full sampled before the edge. A pop in the same cycle does not enable a push.
//   Pointers are ADDR_WIDTH bits and wrap modulo depth. Count is the authoritative full/empty indicator.
//   DataOut is undefined-but-stable when DataValid=0. The FIFO contents are not reset.
//  Status:
//   ClearStatus=1 zeroes ErrorCount and Overrun. If an error increment occurs in the same cycle, the clear wins.
//  Reset mid-operation (any state) returns everything to the reset values. Buffered bytes are discarded.
// TESTING
//  1 Single byte: RxReady=1 with RxDataIn=8'hA5 -> RxEnable high exactly 1 cycle; DataValid=1, DataOut=A5,
//    Count=1 one cycle later; DataRead 1 cycle -> Count=0.
//  2 Fill/back-pressure (ADDR_WIDTH=2): push 4 bytes 01..04 -> Full=1. 5th RxReady held 10 cycles -> no RxEnable.
//    One DataRead -> 5th byte accepted next IDLE. Read order 02,03,04,05.
//  3 Error recovery: RxError=1 in IDLE -> UartResetN low exactly RECOVER_CYCLES=4 cycles, ErrorCount=1,
//    Overrun=0. Then 1 SETTLE cycle and IDLE.
//  4 Error while Full -> Overrun=1 (sticky). 256 errors -> ErrorCount stays 255.
//    ClearStatus concurrent with an error -> both 0.
//  5 Push and pop in the same cycle at Count=2 -> Count stays 2. Pointer wrap over 3x depth pushes with data intact.
//  6 Assert RxSamplerReset during RECOVER and with Count=3 -> all outputs at reset values immediately
//    (async), UartResetN=0 until the first edge after release.

Source files
------------

// File: rtl/uart_rx_fifo_if.sv
// rtl/uart_rx_fifo_if.sv - receiver handshake, FIFO read port and status bundle
// slave is the buffer side; master is whatever drives the receiver and read inputs.
interface uart_rx_fifo_if #(
   parameter int ADDR_WIDTH = 4
);
   logic [7:0]          RxDataIn;
   logic                RxReady;
   logic                RxError;
   logic                RxEnable;
   logic                UartResetN;
   logic [7:0]          DataOut;
   logic                DataValid;
   logic                DataRead;
   logic [ADDR_WIDTH:0] Count;
   logic                Full;
   logic [7:0]          ErrorCount;
   logic                Overrun;
   logic                ClearStatus;

   modport master (
      output RxDataIn, RxReady, RxError, DataRead, ClearStatus,
      input  RxEnable, UartResetN, DataOut, DataValid, Count, Full, ErrorCount, Overrun
   );

   modport slave (
      input  RxDataIn, RxReady, RxError, DataRead, ClearStatus,
      output RxEnable, UartResetN, DataOut, DataValid, Count, Full, ErrorCount, Overrun
   );
endinterface

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART receiver byte buffer with error recovery and statistics
// The receiver only leaves ERROR through reset, so this block pulses UartResetN to recover it.
module uart_rx_fifo #(
   parameter int ADDR_WIDTH     = 4,
   parameter int RECOVER_CYCLES = 4
) (
   input logic           Clk,
   input logic           RxSamplerReset,
   uart_rx_fifo_if.slave bus
);
   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam int CW    = (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES) : 1;
   localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH + 1)'(1);
   localparam logic [ADDR_WIDTH:0]   CNT_FULL = {1'b1, {ADDR_WIDTH{1'b0}}};
   localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);
   localparam logic [CW-1:0]         CNT_LOAD = CW'(RECOVER_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, ACK, RECOVER, SETTLE} state_t;

   state_t                state;
   logic [CW-1:0]         recover_cnt;
   logic [7:0]            mem [DEPTH];
   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic [ADDR_WIDTH-1:0] rd_ptr;
   logic [ADDR_WIDTH-1:0] rd_ptr_inc;
   logic [ADDR_WIDTH:0]   count;
   logic [ADDR_WIDTH:0]   count_next;
   logic                  rx_enable;
   logic                  uart_reset_n;
   logic                  data_valid;
   logic                  full;
   logic                  overrun;
   logic [7:0]            data_out;
   logic [7:0]            error_count;
   logic                  push;
   logic                  pop;
   logic                  take_error;

   // Error beats a ready byte; push uses the Full registered before this edge.
   always_comb begin
      take_error = (state == IDLE) && bus.RxError;
      push       = (state == IDLE) && !bus.RxError && bus.RxReady && !full;
      pop        = bus.DataRead && data_valid;
      rd_ptr_inc = rd_ptr + PTR_ONE;
      count_next = count;
      if (push && !pop) begin
         count_next = count + CNT_ONE;
      end else if (pop && !push) begin
         count_next = count - CNT_ONE;
      end
   end

   always_ff @(posedge Clk or negedge RxSamplerReset) begin
      if (!RxSamplerReset) begin
         state        <= IDLE;
         recover_cnt  <= '0;
         rx_enable    <= 1'b0;
         uart_reset_n <= 1'b0;
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         data_valid   <= 1'b0;
         full         <= 1'b0;
         data_out     <= '0;
         error_count  <= '0;
         overrun      <= 1'b0;
      end else begin
         rx_enable <= 1'b0;
         case (state)
            IDLE: begin
               uart_reset_n <= 1'b1;
               if (bus.RxError) begin
                  uart_reset_n <= 1'b0;
                  recover_cnt  <= CNT_LOAD;
                  state        <= RECOVER;
               end else if (push) begin
                  rx_enable <= 1'b1;
                  state     <= ACK;
               end
            end
            ACK: state <= IDLE;
            RECOVER: begin
               if (recover_cnt == '0) begin
                  uart_reset_n <= 1'b1;
                  state        <= SETTLE;
               end else begin
                  recover_cnt <= recover_cnt - CW'(1);
               end
            end
            SETTLE: state <= IDLE;
            default: state <= IDLE;
         endcase

         if (bus.ClearStatus) begin
            error_count <= '0;
            overrun     <= 1'b0;
         end else if (take_error) begin
            if (error_count != 8'hFF) begin
               error_count <= error_count + 8'd1;
            end
            if (full) begin
               overrun <= 1'b1;
            end
         end

         if (push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (pop) begin
            rd_ptr <= rd_ptr_inc;
         end
         count      <= count_next;
         data_valid <= (count_next != '0);
         full       <= (count_next == CNT_FULL);

         // The head register bypasses memory when the pushed byte becomes the new head.
         if (push && ((count == '0) || (pop && (count == CNT_ONE)))) begin
            data_out <= bus.RxDataIn;
         end else if (pop) begin
            data_out <= mem[rd_ptr_inc];
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (push) begin
         mem[wr_ptr] <= bus.RxDataIn;
      end
   end

   assign bus.RxEnable   = rx_enable;
   assign bus.UartResetN = uart_reset_n;
   assign bus.DataOut    = data_out;
   assign bus.DataValid  = data_valid;
   assign bus.Count      = count;
   assign bus.Full       = full;
   assign bus.ErrorCount = error_count;
   assign bus.Overrun    = overrun;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - directed bench for uart_rx_fifo with a popped-byte scoreboard
// Expected bytes are queued when offered; the monitor compares every pop at the falling edge.
module tb_uart_rx_fifo;
   logic       Clk = 1'b0;
   logic       RxSamplerReset;
   int         total = 0;
   int         bad = 0;
   logic [7:0] exp_q [$];
   logic [7:0] mon_want;
   int         acks;
   int         low;
   int         n;

   uart_rx_fifo_if #(.ADDR_WIDTH(2)) bus ();

   uart_rx_fifo #(
      .ADDR_WIDTH(2),
      .RECOVER_CYCLES(4)
   ) dut (
      .Clk(Clk),
      .RxSamplerReset(RxSamplerReset),
      .bus(bus.slave)
   );

   always #5 Clk = ~Clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, want);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #2;
   endtask

   task automatic read_n(input int cnt);
      bus.DataRead = 1'b1;
      repeat (cnt) tick();
      bus.DataRead = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      int w;
      w = 0;
      exp_q.push_back(b);
      bus.RxDataIn = b;
      bus.RxReady  = 1'b1;
      do begin
         tick();
         w++;
      end while (!bus.RxEnable && w < 20);
      bus.RxReady = 1'b0;
      check("send_ack", 32'(bus.RxEnable), 32'd1);
      tick();
      check("send_ack_pulse", 32'(bus.RxEnable), 32'd0);
   endtask

   task automatic do_error();
      bus.RxError = 1'b1;
      tick();
      bus.RxError = 1'b0;
      repeat (5) tick();
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_rxen"},  32'(bus.RxEnable),   32'd0);
      check({tag, "_urst"},  32'(bus.UartResetN), 32'd0);
      check({tag, "_valid"}, 32'(bus.DataValid),  32'd0);
      check({tag, "_count"}, 32'(bus.Count),      32'd0);
      check({tag, "_full"},  32'(bus.Full),       32'd0);
      check({tag, "_errc"},  32'(bus.ErrorCount), 32'd0);
      check({tag, "_ovr"},   32'(bus.Overrun),    32'd0);
   endtask

   always @(negedge Clk) begin
      if (RxSamplerReset && bus.DataRead && bus.DataValid) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL pop_unexpected: got %0h expected none", bus.DataOut);
         end else begin
            mon_want = exp_q.pop_front();
            check("pop_data", 32'(bus.DataOut), 32'(mon_want));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      RxSamplerReset  = 1'b0;
      bus.RxDataIn    = 8'h00;
      bus.RxReady     = 1'b0;
      bus.RxError     = 1'b0;
      bus.DataRead    = 1'b0;
      bus.ClearStatus = 1'b0;
      repeat (3) tick();
      check_reset_values("rst");
      RxSamplerReset = 1'b1;
      check("rst_urst_hold", 32'(bus.UartResetN), 32'd0);
      tick();
      check("rst_urst_rise", 32'(bus.UartResetN), 32'd1);

      // single byte
      exp_q.push_back(8'hA5);
      bus.RxDataIn = 8'hA5;
      bus.RxReady  = 1'b1;
      tick();
      bus.RxReady = 1'b0;
      check("t1_ack",   32'(bus.RxEnable),  32'd1);
      check("t1_valid", 32'(bus.DataValid), 32'd1);
      check("t1_dout",  32'(bus.DataOut),   32'hA5);
      check("t1_count", 32'(bus.Count),     32'd1);
      tick();
      check("t1_ack_low", 32'(bus.RxEnable), 32'd0);
      read_n(1);
      check("t1_count0", 32'(bus.Count),     32'd0);
      check("t1_valid0", 32'(bus.DataValid), 32'd0);

      // fill and back-pressure
      for (int i = 1; i <= 4; i++) send_byte(8'(i));
      check("t2_full",  32'(bus.Full),  32'd1);
      check("t2_count", 32'(bus.Count), 32'd4);
      exp_q.push_back(8'h05);
      bus.RxDataIn = 8'h05;
      bus.RxReady  = 1'b1;
      acks = 0;
      repeat (10) begin
         tick();
         if (bus.RxEnable) acks++;
      end
      check("t2_bp_noack", 32'(acks), 32'd0);
      bus.DataRead = 1'b1;
      tick();
      bus.DataRead = 1'b0;
      check("t2_pop_count",  32'(bus.Count),    32'd3);
      check("t2_pop_noack",  32'(bus.RxEnable), 32'd0);
      tick();
      check("t2_late_ack",   32'(bus.RxEnable), 32'd1);
      check("t2_late_count", 32'(bus.Count),    32'd4);
      bus.RxReady = 1'b0;
      tick();
      read_n(4);
      check("t2_drained", 32'(bus.Count), 32'd0);

      // error recovery
      bus.RxError = 1'b1;
      tick();
      bus.RxError = 1'b0;
      low = 0;
      n = 0;
      while (bus.UartResetN == 1'b0 && n < 20) begin
         low++;
         tick();
         n++;
      end
      check("t3_low_cycles", 32'(low),            32'd4);
      check("t3_errc",       32'(bus.ErrorCount), 32'd1);
      check("t3_ovr",        32'(bus.Overrun),    32'd0);
      exp_q.push_back(8'h77);
      bus.RxDataIn = 8'h77;
      bus.RxReady  = 1'b1;
      tick();
      check("t3_settle_ignore", 32'(bus.RxEnable), 32'd0);
      tick();
      check("t3_idle_ack", 32'(bus.RxEnable), 32'd1);
      bus.RxReady = 1'b0;
      tick();
      read_n(1);

      // overrun, saturation, clear priority
      send_byte(8'h11);
      send_byte(8'h22);
      send_byte(8'h33);
      send_byte(8'h44);
      check("t4_full", 32'(bus.Full), 32'd1);
      do_error();
      check("t4_ovr",  32'(bus.Overrun),    32'd1);
      check("t4_errc", 32'(bus.ErrorCount), 32'd2);
      read_n(4);
      check("t4_ovr_sticky", 32'(bus.Overrun), 32'd1);
      repeat (256) do_error();
      check("t4_errc_sat", 32'(bus.ErrorCount), 32'd255);
      bus.ClearStatus = 1'b1;
      bus.RxError     = 1'b1;
      tick();
      bus.ClearStatus = 1'b0;
      bus.RxError     = 1'b0;
      check("t4_clr_errc", 32'(bus.ErrorCount), 32'd0);
      check("t4_clr_ovr",  32'(bus.Overrun),    32'd0);
      repeat (5) tick();

      // simultaneous push/pop and pointer wrap
      send_byte(8'hA1);
      send_byte(8'hA2);
      check("t5_count2", 32'(bus.Count), 32'd2);
      exp_q.push_back(8'hA3);
      bus.RxDataIn = 8'hA3;
      bus.RxReady  = 1'b1;
      bus.DataRead = 1'b1;
      tick();
      bus.DataRead = 1'b0;
      bus.RxReady  = 1'b0;
      check("t5_pp_ack",   32'(bus.RxEnable), 32'd1);
      check("t5_pp_count", 32'(bus.Count),    32'd2);
      tick();
      read_n(2);
      for (int r = 0; r < 4; r++) begin
         for (int k = 0; k < 3; k++) send_byte(8'(8'h30 + r * 3 + k));
         read_n(3);
      end
      check("t5_wrap_count", 32'(bus.Count), 32'd0);

      // asynchronous reset during RECOVER with bytes buffered
      send_byte(8'hC1);
      send_byte(8'hC2);
      send_byte(8'hC3);
      check("t6_count3", 32'(bus.Count), 32'd3);
      bus.RxError = 1'b1;
      tick();
      bus.RxError = 1'b0;
      tick();
      check("t6_in_recover", 32'(bus.UartResetN), 32'd0);
      #1;
      RxSamplerReset = 1'b0;
      #1;
      exp_q.delete();
      check_reset_values("t6_async");
      tick();
      check("t6_held_urst", 32'(bus.UartResetN), 32'd0);
      RxSamplerReset = 1'b1;
      check("t6_release_urst", 32'(bus.UartResetN), 32'd0);
      tick();
      check("t6_urst_rise", 32'(bus.UartResetN), 32'd1);
      check("t6_valid",     32'(bus.DataValid),  32'd0);
      send_byte(8'h5A);
      read_n(1);
      check("sb_empty", 32'(exp_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
